alu_share_arbiter: RTL and testbench

- Shares the single combinational ALU of the single-cycle datapath between two requesters: port 0 is the core datapath and port 1 is an auxiliary or debug unit.
- Each request has a valid/ready handshake. The block latches the operands, drives the ALU for one cycle, registers the result and flag, and returns them on a per-port response handshake.
- Arbitration is round-robin. Only one transaction is in flight at a time.

---
 rtl/alu_share_arbiter.sv | 128 ++++++++++++
 tb/tb_alu_share_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Lets two requesters share one combinational ALU. Port 0 is the core
//   datapath and port 1 is an auxiliary/debug unit. One transaction is in
//   flight at a time. The block latches the operands, drives the ALU for one
//   cycle, registers the result and flag, and returns them on a per-port
//   response handshake. Arbitration between the ports is round-robin.
//
// Ports:
//   clk, rst                   clock (rising edge) and asynchronous active-low reset
//   reqN_valid/ready           request handshake for port N (N = 0, 1)
//   reqN_a, reqN_b, reqN_op    request operands and opcode for port N
//   rspN_valid/ready           response handshake for port N
//   rspN_result, rspN_flag     registered ALU result and flag (shared by both ports)
//   alu_a, alu_b, alu_op       latched operands driven to the external ALU
//   alu_result, alu_flag       combinational ALU outputs
module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_result,
  output logic              rsp0_flag,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_result,
  output logic              rsp1_flag,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_flag
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  logic              gnt;
  logic              last;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [OP_W-1:0]   op_code;
  logic [DATA_W-1:0] res;
  logic              flg;

  logic sel_any;
  logic sel;

  // Round-robin pick: a lone requester wins outright; under contention the
  // port that did not own the last completed transaction wins.
  always_comb begin
    sel_any = req0_valid | req1_valid;
    sel     = 1'b0;
    if (req0_valid && req1_valid) sel = ~last;
    else if (req1_valid)          sel = 1'b1;
  end

  // Qualified with rst so that no ready is visible while reset is held.
  assign req0_ready = rst && (state == IDLE) && req0_valid && !sel;
  assign req1_ready = rst && (state == IDLE) && req1_valid &&  sel;

  assign rsp0_valid  = (state == RESP) && !gnt;
  assign rsp1_valid  = (state == RESP) &&  gnt;
  assign rsp0_result = res;
  assign rsp1_result = res;
  assign rsp0_flag   = flg;
  assign rsp1_flag   = flg;

  // The ALU only ever sees latched operands, never live request inputs.
  assign alu_a  = op_a;
  assign alu_b  = op_b;
  assign alu_op = op_code;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      gnt     <= 1'b0;
      last    <= 1'b1;
      op_a    <= '0;
      op_b    <= '0;
      op_code <= '0;
      res     <= '0;
      flg     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Any valid request in IDLE is handshaken by construction of ready.
          if (sel_any) begin
            op_a    <= sel ? req1_a  : req0_a;
            op_b    <= sel ? req1_b  : req0_b;
            op_code <= sel ? req1_op : req0_op;
            gnt     <= sel;
            state   <= EXEC;
          end
        end
        EXEC: begin
          res   <= alu_result;
          flg   <= alu_flag;
          state <= RESP;
        end
        RESP: begin
          if (gnt ? rsp1_ready : rsp0_ready) begin
            last  <= gnt;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

  localparam int DW = 32;
  localparam int OW = 5;

  logic          clk;
  logic          rst;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [OW-1:0] req0_op, req1_op;
  logic          rsp0_valid, rsp0_ready, rsp0_flag;
  logic          rsp1_valid, rsp1_ready, rsp1_flag;
  logic [DW-1:0] rsp0_result, rsp1_result;
  logic [DW-1:0] alu_a, alu_b, alu_result;
  logic [OW-1:0] alu_op;
  logic          alu_flag;

  int unsigned tests = 0;
  int unsigned fails = 0;

  alu_share_arbiter #(.DATA_W(DW), .OP_W(OW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_result(rsp0_result), .rsp0_flag(rsp0_flag),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_result(rsp1_result), .rsp1_flag(rsp1_flag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_flag(alu_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 BLT (flag = signed a<b).
  function automatic logic [DW:0] alu_fn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                         input logic [OW-1:0] op);
    logic [DW-1:0] r;
    logic          f;
    f = (a == b);
    case (op)
      5'd0: r = a + b;
      5'd1: r = a - b;
      5'd2: r = a & b;
      5'd3: r = a | b;
      5'd4: r = a ^ b;
      5'd5: begin r = a - b; f = ($signed(a) < $signed(b)); end
      default: r = a;
    endcase
    return {f, r};
  endfunction

  always_comb {alu_flag, alu_result} = alu_fn(alu_a, alu_b, alu_op);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Transaction-level reference: at most one outstanding op, response visible
  // two edges after acceptance, round-robin against the last completed owner.
  logic          m_busy, m_port, m_last;
  int unsigned   m_age;
  logic [DW-1:0] m_a, m_b, m_res;
  logic [OW-1:0] m_op;
  logic          m_flg;
  logic          obs_r0, obs_r1, obs_v0, obs_v1, obs_f0, obs_f1;
  logic [DW-1:0] obs_res0, obs_res1;

  // Called with inputs set just after a rising edge; checks at the falling
  // edge, advances the model, and returns 1 time unit after the next rising edge.
  task automatic cyc();
    logic e_r0, e_r1, e_v0, e_v1, sel;
    @(negedge clk);
    obs_r0 = req0_ready; obs_r1 = req1_ready;
    obs_v0 = rsp0_valid; obs_v1 = rsp1_valid;
    obs_res0 = rsp0_result; obs_res1 = rsp1_result;
    obs_f0 = rsp0_flag; obs_f1 = rsp1_flag;
    e_r0 = 1'b0; e_r1 = 1'b0; sel = 1'b0;
    if (rst && !m_busy) begin
      if (req0_valid && req1_valid) sel = ~m_last;
      else sel = req1_valid;
      e_r0 = req0_valid && !sel;
      e_r1 = req1_valid && sel;
    end
    e_v0 = rst && m_busy && (m_age >= 2) && !m_port;
    e_v1 = rst && m_busy && (m_age >= 2) &&  m_port;
    chk("req0_ready", obs_r0, e_r0);
    chk("req1_ready", obs_r1, e_r1);
    chk("rsp0_valid", obs_v0, e_v0);
    chk("rsp1_valid", obs_v1, e_v1);
    if (rst && m_busy) begin
      chk("alu_a", alu_a, m_a);
      chk("alu_b", alu_b, m_b);
      chk("alu_op", alu_op, m_op);
    end
    if (e_v0 || e_v1) begin
      chk("rsp0_result", obs_res0, m_res);
      chk("rsp1_result", obs_res1, m_res);
      chk("rsp0_flag", obs_f0, m_flg);
      chk("rsp1_flag", obs_f1, m_flg);
    end
    if (!rst) begin
      m_busy = 1'b0; m_last = 1'b1;
    end else if (!m_busy) begin
      if (e_r0 || e_r1) begin
        m_busy = 1'b1; m_age = 1; m_port = e_r1;
        m_a  = e_r1 ? req1_a  : req0_a;
        m_b  = e_r1 ? req1_b  : req0_b;
        m_op = e_r1 ? req1_op : req0_op;
        {m_flg, m_res} = alu_fn(m_a, m_b, m_op);
      end
    end else if (m_age >= 2) begin
      if (m_port ? rsp1_ready : rsp0_ready) begin
        m_busy = 1'b0; m_last = m_port;
      end
    end else begin
      m_age++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cyc();
    cyc();
    rst = 1'b1;
  endtask

  task automatic single(input logic port, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [OW-1:0] op, output logic [DW-1:0] r, output logic f);
    int unsigned got;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    if (port) begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op; end
    else      begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op; end
    got = 0;
    for (int i = 0; i < 10 && got == 0; i++) begin
      cyc();
      if (port ? obs_r1 : obs_r0) got = 1;
    end
    chk("single_accept", got, 1);
    req0_valid = 1'b0; req1_valid = 1'b0;
    got = 0; r = '0; f = 1'b0;
    for (int i = 0; i < 10 && got == 0; i++) begin
      cyc();
      if (port ? obs_v1 : obs_v0) begin
        got = 1;
        r = port ? obs_res1 : obs_res0;
        f = port ? obs_f1 : obs_f0;
      end
    end
    chk("single_response", got, 1);
  endtask

  initial begin
    logic [DW-1:0] r, held;
    logic          f;
    int unsigned   acc_port[$];
    int unsigned   acc_cyc[$];
    int unsigned   nrsp;
    m_busy = 1'b0; m_last = 1'b1; m_age = 0; m_port = 1'b0;
    m_a = '0; m_b = '0; m_op = '0; m_res = '0; m_flg = 1'b0;
    rst = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    #2;

    // Reset state: requests present but nothing may be accepted.
    rst = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    cyc();
    chk("reset_alu_a", alu_a, 0);
    chk("reset_result", rsp0_result, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    cyc();
    rst = 1'b1;

    // Single op: ADD 5+7 on port 0.
    req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd7; req0_op = 5'd0;
    cyc();
    chk("single_ready0", obs_r0, 1);
    chk("single_ready1", obs_r1, 0);
    req0_valid = 1'b0;
    cyc();
    chk("single_exec_v0", obs_v0, 0);
    cyc();
    chk("single_rsp0_valid", obs_v0, 1);
    chk("single_rsp0_result", obs_res0, 12);
    chk("single_rsp1_valid", obs_v1, 0);
    cyc();

    // Contention: grants alternate starting at port 0, one accept every 3 cycles.
    do_reset();
    req0_valid = 1'b1; req0_a = 32'h10; req0_b = 32'h1; req0_op = 5'd0;
    req1_valid = 1'b1; req1_a = 32'h20; req1_b = 32'h2; req1_op = 5'd0;
    nrsp = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (obs_r0) begin acc_port.push_back(0); acc_cyc.push_back(i); end
      if (obs_r1) begin acc_port.push_back(1); acc_cyc.push_back(i); end
      if (obs_v0 && obs_res0 == 32'h11) nrsp++;
      if (obs_v1 && obs_res1 == 32'h22) nrsp++;
    end
    chk("contention_accepts", acc_port.size(), 4);
    chk("contention_responses", nrsp, 4);
    if (acc_port.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        chk("contention_grant", acc_port[k], k % 2);
        chk("contention_spacing", acc_cyc[k], 3 * k);
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int i = 0; i < 3; i++) cyc();

    // Backpressure on port 1 blocks port 0.
    rsp1_ready = 1'b0;
    req1_valid = 1'b1; req1_a = 32'd7; req1_b = 32'd8; req1_op = 5'd0;
    cyc();
    chk("bp_accept1", obs_r1, 1);
    req1_valid = 1'b0;
    cyc();
    cyc();
    chk("bp_rsp1_rise", obs_v1, 1);
    held = obs_res1;
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_op = 5'd0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("bp_ready0_blocked", obs_r0, 0);
      chk("bp_rsp1_hold", obs_v1, 1);
      chk("bp_result_hold", obs_res1, held);
      chk("bp_result_value", obs_res1, 15);
    end
    rsp1_ready = 1'b1;
    cyc();
    chk("bp_ready0_same_cycle", obs_r0, 0);
    cyc();
    chk("bp_ready0_after", obs_r0, 1);
    req0_valid = 1'b0;
    for (int i = 0; i < 3; i++) cyc();

    // Flag path.
    single(1'b0, 32'hFFFF_FFFF, 32'd1, 5'd5, r, f);
    chk("blt_flag_neg", f, 1);
    single(1'b1, 32'd3, 32'd1, 5'd5, r, f);
    chk("blt_flag_pos", f, 0);
    chk("blt_result", r, 2);

    // Operand isolation: operands change during EXEC.
    req0_valid = 1'b1; req0_a = 32'd100; req0_b = 32'd1; req0_op = 5'd0;
    cyc();
    chk("iso_accept", obs_r0, 1);
    req0_valid = 1'b0; req0_a = 32'd999;
    cyc();
    chk("iso_alu_a", alu_a, 100);
    cyc();
    chk("iso_result", obs_res0, 101);
    cyc();

    // Reset mid-transaction (in EXEC).
    req1_valid = 1'b1; req1_a = 32'd4; req1_b = 32'd4; req1_op = 5'd1;
    cyc();
    chk("midrst_accept1", obs_r1, 1);
    req0_valid = 1'b1; req0_a = 32'd9; req0_b = 32'd9; req0_op = 5'd2;
    rst = 1'b0;
    #1;
    chk("midrst_alu_a", alu_a, 0);
    chk("midrst_alu_op", alu_op, 0);
    chk("midrst_ready0", req0_ready, 0);
    chk("midrst_ready1", req1_ready, 0);
    chk("midrst_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
    chk("midrst_result", rsp1_result, 0);
    cyc();
    rst = 1'b1;
    cyc();
    chk("midrst_port0_first", obs_r0, 1);
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int i = 0; i < 3; i++) cyc();

    // Randomized traffic; requesters hold valid/operands until ready.
    for (int i = 0; i < 600; i++) begin
      if (!req0_valid || obs_r0) begin
        req0_valid = ($urandom_range(0, 1) == 1);
        req0_a = $urandom; req0_b = $urandom; req0_op = 5'($urandom_range(0, 6));
      end
      if (!req1_valid || obs_r1) begin
        req1_valid = ($urandom_range(0, 2) != 0);
        req1_a = $urandom; req1_b = $urandom; req1_op = 5'($urandom_range(0, 6));
      end
      rsp0_ready = ($urandom_range(0, 2) != 0);
      rsp1_ready = ($urandom_range(0, 1) == 1);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
